cra_nibble_serial_adder: RTL and testbench

Digit-serial wide adder sitting directly upstream of the 4-bit ripple-carry slice. Accepts a WIDTH-bit operand pair over a valid/ready handshake, feeds the pair one 4-bit nibble per cycle (LSB first) through a 4-bit ripple-carry slice, and registers the inter-nibble carry. Assembles the WIDTH-bit sum and final carry and presents them over an output valid/ready handshake. Trades latency for area against a full-width ripple adder.

---
 rtl/cra_pkg.sv | 19 +
 rtl/cra4bitscin.sv | 40 ++++
 rtl/cra_nibble_serial_adder.sv | 167 ++++++++++++++++
 tb/tb_cra_nibble_serial_adder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cra_pkg.sv
// Shared definitions for the nibble-serial carry-ripple adder.
package cra_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index for a given operand width (at least 1 bit).
    function automatic int idx_width(input int width);
        int n;
        n = width / NIBBLE;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cra4bitscin.sv
// 4-bit ripple-carry slice with explicit carry-in; also exports the carry
// into bit 3 so the caller can derive signed overflow.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module cra4bitscin
    import cra_pkg::*;
(
    input  logic [NIBBLE-1:0] i_a,
    input  logic [NIBBLE-1:0] i_b,
    input  logic              i_cin,
    output logic [NIBBLE-1:0] o_sum,
    output logic              o_cout,
    output logic              o_c3
);
    logic [NIBBLE:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar k = 0; k < NIBBLE; k++) begin : g_fa
        full_adder u_fa (
            .a    (i_a[k]),
            .b    (i_b[k]),
            .cin  (w_c[k]),
            .s    (o_sum[k]),
            .cout (w_c[k+1])
        );
    end

    assign o_cout = w_c[NIBBLE];
    assign o_c3   = w_c[NIBBLE-1];
endmodule

// File: rtl/cra_nibble_serial_adder.sv
// Digit-serial WIDTH-bit adder: one nibble per cycle through a 4-bit slice.
// Optional signed-overflow output ovf enabled by defining CRA_SERIAL_OVF_EN.
module cra_nibble_serial_adder
    import cra_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef CRA_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int N     = WIDTH / NIBBLE;
    localparam int IDX_W = idx_width(WIDTH);

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_s;
    logic              r_carry;
    logic [IDX_W-1:0]  r_idx;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_ovf;
    logic              w_in_ready_d;
    logic              w_out_valid_d;
    logic              w_last;
    logic [IDX_W+1:0]  w_shift;
    logic [NIBBLE-1:0] w_a_nib;
    logic [NIBBLE-1:0] w_b_nib;
    logic [NIBBLE-1:0] w_sum;
    logic              w_cout;
    logic              w_c3;

    assign w_last  = (r_idx == IDX_W'(N - 1));
    assign w_shift = {r_idx, 2'b00};
    assign w_a_nib = NIBBLE'(r_a >> w_shift);
    assign w_b_nib = NIBBLE'(r_b >> w_shift);

    cra4bitscin u_slice (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_c3   (w_c3)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state, then registered below.
    always_comb begin
        w_in_ready_d  = 1'b0;
        w_out_valid_d = 1'b0;
        case (w_state_next)
            IDLE:    w_in_ready_d  = 1'b1;
            DONE:    w_out_valid_d = 1'b1;
            default: begin
                w_in_ready_d  = 1'b0;
                w_out_valid_d = 1'b0;
            end
        endcase
    end

    // Operand capture, per-nibble accumulation and handshake output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_s         <= {WIDTH{1'b0}};
            r_carry     <= 1'b0;
            r_idx       <= {IDX_W{1'b0}};
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_d;
            r_out_valid <= w_out_valid_d;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= 1'b0;
                        r_idx   <= {IDX_W{1'b0}};
                    end
                end
                RUN: begin
                    r_s     <= (r_s & ~(WIDTH'(4'hF) << w_shift))
                             | (WIDTH'(w_sum) << w_shift);
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_idx <= {IDX_W{1'b0}};
                        r_ovf <= w_c3 ^ w_cout;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    r_idx <= r_idx;
                end
                default: begin
                    r_idx <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign cout      = r_carry;
`ifdef CRA_SERIAL_OVF_EN
    assign ovf       = r_ovf;
`else
    logic w_ovf_unused;
    assign w_ovf_unused = r_ovf;
`endif

endmodule

// File: tb/tb_cra_nibble_serial_adder.sv
// Scoreboard bench for cra_nibble_serial_adder (WIDTH=16, directed vectors).
module tb_cra_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int N     = 4;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] a = 16'h0000;
    logic [WIDTH-1:0] b = 16'h0000;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef CRA_SERIAL_OVF_EN
    logic             ovf;
`endif

    exp_t q[$];
    int   total    = 0;
    int   bad      = 0;
    int   n_pushed = 0;
    int   n_seen   = 0;

    cra_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef CRA_SERIAL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected result at every output handshake.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got s=%h cout=%b expected no result", s, cout);
                end else begin
                    e = q.pop_front();
                    n_seen++;
                    check("sum", 32'(s), 32'(e.s));
                    check("cout", 32'(cout), 32'(e.cout));
`ifdef CRA_SERIAL_OVF_EN
                    check("ovf", 32'(ovf), 32'(e.ovf));
`endif
                end
            end
        end
    end

    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input exp_t e, input bit chk_rise, input string name);
        int cyc;
        bit seen;
        cyc = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_ready_before"}, 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        q.push_back(e);
        n_pushed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({name, "_ready_drop"}, 32'(in_ready), 32'd0);
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 20 && !seen) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = (out_valid === 1'b1);
        end
        check({name, "_latency"}, 32'(cyc), 32'(N));
        if (chk_rise) begin
            @(posedge clk);
            #1;
            check({name, "_ready_rise"}, 32'(in_ready), 32'd1);
            check({name, "_valid_fall"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin : stim
        bit pulse;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(16'h1234, 16'h4321, '{s: 16'h5555, cout: 1'b0, ovf: 1'b0}, 1'b1, "basic");
        do_op(16'hFFFF, 16'h0001, '{s: 16'h0000, cout: 1'b1, ovf: 1'b0}, 1'b1, "ripple");

        // Backpressure: result must hold while a second pair is offered.
        out_ready = 1'b0;
        do_op(16'h8000, 16'h8000, '{s: 16'h0000, cout: 1'b1, ovf: 1'b1}, 1'b0, "bp");
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 16'h1111;
            b        = 16'h2222;
            #1;
            check("bp_hold_s", 32'(s), 32'h0000);
            check("bp_hold_cout", 32'(cout), 32'd1);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready_rise", 32'(in_ready), 32'd1);
        check("bp_valid_fall", 32'(out_valid), 32'd0);

        // Reset after two RUN cycles discards the operation.
        @(negedge clk);
        a        = 16'hAAAA;
        b        = 16'h5555;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_s", 32'(s), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        pulse = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) pulse = 1'b1;
        end
        check("midrst_no_pulse", 32'(pulse), 32'd0);
        do_op(16'h00FF, 16'h0001, '{s: 16'h0100, cout: 1'b0, ovf: 1'b0}, 1'b1, "after_rst");

`ifdef CRA_SERIAL_OVF_EN
        do_op(16'h7FFF, 16'h0001, '{s: 16'h8000, cout: 1'b0, ovf: 1'b1}, 1'b1, "ovf_pos");
        do_op(16'hFFFF, 16'h0001, '{s: 16'h0000, cout: 1'b1, ovf: 1'b0}, 1'b1, "ovf_wrap");
`endif

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", 32'(q.size()), 32'd0);
        check("result_count", 32'(n_seen), 32'(n_pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
